// File: rtl/serial_sub_8.sv
// Bit-serial subtractor: d = a - b - bi, computed LSB first, one bit per clock.
// A start pulse in IDLE captures the operands. After W shift cycles the result,
// borrow-out and signed overflow are published together with a one-cycle done
// pulse. d/bo/of hold the previous result while a new operation is running.
module serial_sub_8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         of,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic         state;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-2:0] res_reg;
  logic         borrow;
  logic [CW-1:0] cnt;
  logic         a_msb;
  logic         b_msb;

  logic         x;
  logic         y;
  logic         diff_bit;
  logic         borrow_next;
  logic         last;
  logic [W-1:0] res_next;

  // One full-subtractor slice on the current LSBs; res_next is the result
  // register with the new bit shifted in at the top, complete on the last cycle.
  always_comb begin
    x           = a_reg[0];
    y           = b_reg[0];
    diff_bit    = x ^ y ^ borrow;
    borrow_next = (~x & y) | (~(x ^ y) & borrow);
    last        = (cnt == CW'(W - 1));
    res_next    = {diff_bit, res_reg};
  end

  // Handshake, operand capture, serial shifting and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      d       <= '0;
      bo      <= 1'b0;
      of      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= bi;
            a_msb  <= a[W-1];
            b_msb  <= b[W-1];
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= res_next[W-1:1];
          borrow  <= borrow_next;
          cnt     <= cnt + CW'(1);
          if (last) begin
            d     <= res_next;
            bo    <= borrow_next;
            of    <= (a_msb & ~b_msb & ~diff_bit) | (~a_msb & b_msb & diff_bit);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_8.sv
// Bench for serial_sub_8: directed vector table, hand-written multi-cycle
// sequences (mid-operation start, back-to-back, reset abort) and random
// operations checked against a plain-arithmetic reference model.
module tb_serial_sub_8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bi;
  logic [7:0] d;
  logic       bo;
  logic       of;
  logic       busy;
  logic       done;

  int nChecks;
  int nFails;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] expD;
    logic       expBo;
    logic       expOf;
    logic       disturb;
  } vec_t;

  vec_t vecs[7];

  serial_sub_8 #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .d     (d),
    .bo    (bo),
    .of    (of),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: subtraction done with 9-bit integer arithmetic.
  function automatic logic [9:0] refModel(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic rbi);
    logic [8:0] full;
    logic [7:0] rd;
    logic       rof;
    full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
    rd   = full[7:0];
    rof  = (ra[7] != rb[7]) && (rd[7] != ra[7]);
    return {full[8], rof, rd};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation. Returns latency in cycles from the start edge to done
  // (0 on timeout), the number of cycles busy was seen high, and whether
  // d/bo/of stayed put until completion. With disturb set, operands change and
  // start is pulsed mid-operation. With noWait set, start is driven in the
  // current cycle (used for back-to-back issue in the done cycle).
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tbi,
                               input logic disturb, input logic noWait,
                               output int lat, output int busyCycles, output logic held);
    logic [9:0] prev;
    if (!noWait) @(negedge clk);
    prev  = {bo, of, d};
    a     = ta;
    b     = tb;
    bi    = tbi;
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    a          = $urandom;
    b          = $urandom;
    bi         = $urandom;
    lat        = 0;
    busyCycles = 0;
    held       = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busyCycles++;
      if (disturb && k == 3) begin
        a     = $urandom;
        b     = $urandom;
        bi    = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if ({bo, of, d} !== prev) held = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [7:0] ta, input logic [7:0] tb,
                             input logic tbi, input logic disturb, input logic noWait);
    int         lat;
    int         busyCycles;
    logic       held;
    logic [9:0] exp;
    exp = refModel(ta, tb, tbi);
    applyStimulus(ta, tb, tbi, disturb, noWait, lat, busyCycles, held);
    checkOutput({name, " latency"}, lat, 8);
    checkOutput({name, " busy cycles"}, busyCycles, 8);
    checkOutput({name, " hold"}, held, 1);
    checkOutput({name, " d"}, d, exp[7:0]);
    checkOutput({name, " bo"}, bo, exp[9]);
    checkOutput({name, " of"}, of, exp[8]);
    checkOutput({name, " busy at done"}, busy, 0);
  endtask

  initial begin
    int         lat;
    int         busyCycles;
    logic       held;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbi;

    nChecks = 0;
    nFails  = 0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    bi    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset d", d, 8'h00);
    checkOutput("reset flags", {bo, of, busy, done}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].disturb, 1'b0,
                    lat, busyCycles, held);
      checkOutput($sformatf("vec%0d latency", i), lat, 8);
      checkOutput($sformatf("vec%0d busy cycles", i), busyCycles, 8);
      checkOutput($sformatf("vec%0d hold", i), held, 1);
      checkOutput($sformatf("vec%0d d", i), d, vecs[i].expD);
      checkOutput($sformatf("vec%0d bo", i), bo, vecs[i].expBo);
      checkOutput($sformatf("vec%0d of", i), of, vecs[i].expOf);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done pulse width", i), done, 0);
    end

    $display("[TB] back-to-back");
    runAndCheck("b2b first", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    runAndCheck("b2b second", 8'h03, 8'h05, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b second d const", d, 8'hFE);

    $display("[TB] reset mid-operation");
    runAndCheck("pre-reset", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a     = 8'hAA;
    b     = 8'h11;
    bi    = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort d", d, 8'h00);
    checkOutput("abort flags", {bo, of, busy, done}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    held  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) held = 1'b0;
    end
    checkOutput("abort no done", held, 1);
    runAndCheck("post-reset", 8'h09, 8'h04, 1'b0, 1'b0, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 25; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rbi = $urandom;
      runAndCheck($sformatf("rand%0d", i), ra, rb, rbi, (i % 5) == 0, (i % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
